// File: rtl/register_file_pkg.sv
// Shared types and default sizing for the architectural register file.
package regfile_pkg;
  localparam int WIDTH        = 16;
  localparam int SELECT_WIDTH = 4;
  localparam int NUM_REGS     = 2 ** SELECT_WIDTH;

  typedef logic [WIDTH-1:0]        word_t;
  typedef logic [SELECT_WIDTH-1:0] reg_idx_t;

  typedef enum logic {
    RESET = 1'b0,
    READY = 1'b1
  } rf_state_t;
endpackage

// File: rtl/register_file_if.sv
// Write-back, reservation and read-port bundle of the register file.
interface register_file_if #(
    parameter int WIDTH        = 16,
    parameter int SELECT_WIDTH = 4
);
    logic                         wr_valid;
    logic                         wr_ready;
    logic [SELECT_WIDTH-1:0]      wr_index;
    logic [WIDTH-1:0]             wr_data;
    logic                         rsv_valid;
    logic [SELECT_WIDTH-1:0]      rsv_index;
    logic                         rsv_ready;
    logic [SELECT_WIDTH-1:0]      rd_index_a;
    logic [SELECT_WIDTH-1:0]      rd_index_b;
    logic [WIDTH-1:0]             rd_data_a;
    logic [WIDTH-1:0]             rd_data_b;
    logic                         rd_busy_a;
    logic                         rd_busy_b;
    logic [2**SELECT_WIDTH-1:0]   busy;
    logic                         err;

    modport master (
        output wr_valid, wr_index, wr_data, rsv_valid, rsv_index, rd_index_a, rd_index_b,
        input  wr_ready, rsv_ready, rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, busy, err
    );

    modport slave (
        input  wr_valid, wr_index, wr_data, rsv_valid, rsv_index, rd_index_a, rd_index_b,
        output wr_ready, rsv_ready, rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, busy, err
    );
endinterface

// File: rtl/register_file_multiplexer.sv
// Read-port selector: picks one word out of the register array.
module Multiplexer #(
    parameter int WIDTH        = 16,
    parameter int SELECT_WIDTH = 4
) (
    input  logic [WIDTH-1:0]        i_data [2**SELECT_WIDTH],
    input  logic [SELECT_WIDTH-1:0] i_sel,
    output logic [WIDTH-1:0]        o_data
);
    assign o_data = i_data[i_sel];
endmodule

// File: rtl/register_file.sv
// Architectural register file with busy scoreboard and two combinational read ports.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_BYPASS_EN.
module register_file #(
    parameter int WIDTH        = regfile_pkg::WIDTH,
    parameter int SELECT_WIDTH = regfile_pkg::SELECT_WIDTH
) (
    input logic             clk,
    input logic             reset_n,
    register_file_if.slave  bus
);
    import regfile_pkg::*;

    localparam int NUM_REGS = 2 ** SELECT_WIDTH;

    rf_state_t             r_state;
    rf_state_t             w_state_next;
    logic [WIDTH-1:0]      r_regs   [NUM_REGS];
    logic [WIDTH-1:0]      w_mux_in [NUM_REGS];
    logic [NUM_REGS-1:0]   r_busy;
    logic                  r_err;
    logic                  w_ready;
    logic                  w_wr_fire;
    logic                  w_wr_nz;
    logic                  w_rsv_ready;
    logic                  w_rsv_fire;
    logic [WIDTH-1:0]      w_mux_a;
    logic [WIDTH-1:0]      w_mux_b;
    logic                  w_byp_a;
    logic                  w_byp_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= RESET;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RESET: w_state_next = READY;
            READY: w_state_next = READY;
        endcase
    end

    assign w_ready     = (r_state == READY);
    assign w_wr_fire   = bus.wr_valid && w_ready;
    assign w_wr_nz     = (bus.wr_index != '0);
    // A write landing on the same index this cycle frees the slot, so a WAW reservation may chain.
    assign w_rsv_ready = w_ready && ((bus.rsv_index == '0) || !r_busy[bus.rsv_index] ||
                                     (w_wr_fire && bus.wr_index == bus.rsv_index));
    assign w_rsv_fire  = bus.rsv_valid && w_rsv_ready;

    // NOTE: the array is architectural state, so it is reset along with everything else;
    // register 0 is only ever written by reset, which keeps it at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_wr_fire && w_wr_nz) begin
                r_regs[bus.wr_index] <= bus.wr_data;
                r_busy[bus.wr_index] <= 1'b0;
                if (!r_busy[bus.wr_index]) r_err <= 1'b1;
            end
            // Issued after the clear so a same-index reservation keeps the bit set.
            if (w_rsv_fire && bus.rsv_index != '0) r_busy[bus.rsv_index] <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) w_mux_in[i] = r_regs[i];
        w_mux_in[0] = '0;
    end

    Multiplexer #(.WIDTH(WIDTH), .SELECT_WIDTH(SELECT_WIDTH)) u_mux_a (
        .i_data (w_mux_in),
        .i_sel  (bus.rd_index_a),
        .o_data (w_mux_a)
    );

    Multiplexer #(.WIDTH(WIDTH), .SELECT_WIDTH(SELECT_WIDTH)) u_mux_b (
        .i_data (w_mux_in),
        .i_sel  (bus.rd_index_b),
        .o_data (w_mux_b)
    );

`ifdef REG_BYPASS_EN
    assign w_byp_a = w_wr_fire && w_wr_nz && (bus.wr_index == bus.rd_index_a);
    assign w_byp_b = w_wr_fire && w_wr_nz && (bus.wr_index == bus.rd_index_b);
`else
    assign w_byp_a = 1'b0;
    assign w_byp_b = 1'b0;
`endif

    assign bus.rd_data_a = w_byp_a ? bus.wr_data : w_mux_a;
    assign bus.rd_data_b = w_byp_b ? bus.wr_data : w_mux_b;
    assign bus.rd_busy_a = r_busy[bus.rd_index_a] && !w_byp_a;
    assign bus.rd_busy_b = r_busy[bus.rd_index_b] && !w_byp_b;
    assign bus.wr_ready  = w_ready;
    assign bus.rsv_ready = w_rsv_ready;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file; honours REG_BYPASS_EN when defined.
module tb_register_file;
    import regfile_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] v;
    } exp_t;

    logic clk;
    logic reset_n;
    exp_t        sb_exp [$];
    logic [31:0] sb_obs [$];
    int          n_cmp;
    int          n_mis;
    word_t       mdl [NUM_REGS];

    register_file_if #(.WIDTH(WIDTH), .SELECT_WIDTH(SELECT_WIDTH)) bus ();

    register_file #(.WIDTH(WIDTH), .SELECT_WIDTH(SELECT_WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void expect_v(input string name, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.v    = v;
        sb_exp.push_back(e);
    endfunction

    function automatic void observe(input logic [31:0] v);
        sb_obs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid   = 1'b0;
        bus.wr_index   = '0;
        bus.wr_data    = '0;
        bus.rsv_valid  = 1'b0;
        bus.rsv_index  = '0;
        bus.rd_index_a = '0;
        bus.rd_index_b = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #2;
        expect_v("rst_wr_ready", 0);   observe(bus.wr_ready);
        expect_v("rst_rsv_ready", 0);  observe(bus.rsv_ready);
        expect_v("rst_busy", 0);       observe(bus.busy);
        expect_v("rst_err", 0);        observe(bus.err);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        expect_v("pre_edge_wr_ready", 0);  observe(bus.wr_ready);
        expect_v("pre_edge_rsv_ready", 0); observe(bus.rsv_ready);
        tick();
        expect_v("post_edge_wr_ready", 1);  observe(bus.wr_ready);
        expect_v("post_edge_rsv_ready", 1); observe(bus.rsv_ready);
        while (sb_exp.size() > 0) begin
            exp_t e = sb_exp.pop_front();
            logic [31:0] o = sb_obs.pop_front();
            n_cmp++;
            if (o !== e.v) begin n_mis++; $display("FAIL %s: got %0h expected %0h", e.name, o, e.v); end
        end
    endtask

    task automatic test_reserve_write();
        bus.rsv_valid = 1'b1; bus.rsv_index = 4'd3;
        #1;
        expect_v("r3_rsv_ready", 1); observe(bus.rsv_ready);
        tick();
        bus.rsv_valid = 1'b0;
        #1;
        expect_v("r3_busy_set", 1); observe(bus.busy[3]);
        bus.wr_valid = 1'b1; bus.wr_index = 4'd3; bus.wr_data = 16'hBEEF; bus.rd_index_a = 4'd3;
        mdl[3] = 16'hBEEF;
        tick();
        bus.wr_valid = 1'b0;
        #1;
        expect_v("r3_read", mdl[3]);  observe(bus.rd_data_a);
        expect_v("r3_busy_clr", 0);   observe(bus.busy[3]);
        expect_v("r3_err", 0);        observe(bus.err);
        while (sb_exp.size() > 0) begin
            exp_t e = sb_exp.pop_front();
            logic [31:0] o = sb_obs.pop_front();
            n_cmp++;
            if (o !== e.v) begin n_mis++; $display("FAIL %s: got %0h expected %0h", e.name, o, e.v); end
        end
    endtask

    task automatic test_waw();
        bus.rsv_valid = 1'b1; bus.rsv_index = 4'd5;
        tick();
        bus.rd_index_a = 4'd5;
        #1;
        expect_v("r5_rd_busy_a", 1);   observe(bus.rd_busy_a);
        expect_v("r5_waw_stall", 0);   observe(bus.rsv_ready);
        tick();
        expect_v("r5_waw_stall2", 0);  observe(bus.rsv_ready);
        bus.wr_valid = 1'b1; bus.wr_index = 4'd5; bus.wr_data = 16'h1234;
        #1;
        expect_v("r5_rsv_with_wr", 1); observe(bus.rsv_ready);
`ifdef REG_BYPASS_EN
        expect_v("r5_same_cycle_data", 16'h1234); observe(bus.rd_data_a);
        expect_v("r5_same_cycle_busy", 0);        observe(bus.rd_busy_a);
`else
        expect_v("r5_same_cycle_data", 16'h0000); observe(bus.rd_data_a);
        expect_v("r5_same_cycle_busy", 1);        observe(bus.rd_busy_a);
`endif
        mdl[5] = 16'h1234;
        tick();
        bus.wr_valid = 1'b0; bus.rsv_valid = 1'b0; bus.rd_index_b = 4'd5;
        #1;
        expect_v("r5_busy_kept", 1);  observe(bus.busy[5]);
        expect_v("r5_read_b", mdl[5]); observe(bus.rd_data_b);
        expect_v("r5_err", 0);        observe(bus.err);
        bus.wr_valid = 1'b1; bus.wr_index = 4'd5; bus.wr_data = 16'h5555;
        mdl[5] = 16'h5555;
        tick();
        bus.wr_valid = 1'b0;
        #1;
        expect_v("r5_busy_clr", 0);    observe(bus.busy[5]);
        expect_v("r5_read_b2", mdl[5]); observe(bus.rd_data_b);
        while (sb_exp.size() > 0) begin
            exp_t e = sb_exp.pop_front();
            logic [31:0] o = sb_obs.pop_front();
            n_cmp++;
            if (o !== e.v) begin n_mis++; $display("FAIL %s: got %0h expected %0h", e.name, o, e.v); end
        end
    endtask

    task automatic test_reg0();
        bus.wr_valid = 1'b1; bus.wr_index = 4'd0; bus.wr_data = 16'hFFFF;
        bus.rsv_valid = 1'b1; bus.rsv_index = 4'd0; bus.rd_index_a = 4'd0;
        #1;
        expect_v("r0_rsv_ready", 1);  observe(bus.rsv_ready);
        expect_v("r0_same_cycle", 0); observe(bus.rd_data_a);
        tick();
        bus.wr_valid = 1'b0; bus.rsv_valid = 1'b0;
        #1;
        expect_v("r0_read", 0); observe(bus.rd_data_a);
        expect_v("r0_busy", 0); observe(bus.busy[0]);
        expect_v("r0_err", 0);  observe(bus.err);
        while (sb_exp.size() > 0) begin
            exp_t e = sb_exp.pop_front();
            logic [31:0] o = sb_obs.pop_front();
            n_cmp++;
            if (o !== e.v) begin n_mis++; $display("FAIL %s: got %0h expected %0h", e.name, o, e.v); end
        end
    endtask

    task automatic test_bypass();
        bus.rsv_valid = 1'b1; bus.rsv_index = 4'd9;
        tick();
        bus.rsv_valid = 1'b0;
        bus.wr_valid = 1'b1; bus.wr_index = 4'd9; bus.wr_data = 16'hA5A5; bus.rd_index_a = 4'd9;
        #1;
`ifdef REG_BYPASS_EN
        expect_v("r9_same_cycle_data", 16'hA5A5); observe(bus.rd_data_a);
        expect_v("r9_same_cycle_busy", 0);        observe(bus.rd_busy_a);
`else
        expect_v("r9_same_cycle_data", mdl[9]);   observe(bus.rd_data_a);
        expect_v("r9_same_cycle_busy", 1);        observe(bus.rd_busy_a);
`endif
        mdl[9] = 16'hA5A5;
        tick();
        bus.wr_valid = 1'b0;
        #1;
        expect_v("r9_read", mdl[9]); observe(bus.rd_data_a);
        expect_v("r9_busy", 0);      observe(bus.rd_busy_a);
        expect_v("r9_err", 0);       observe(bus.err);
        while (sb_exp.size() > 0) begin
            exp_t e = sb_exp.pop_front();
            logic [31:0] o = sb_obs.pop_front();
            n_cmp++;
            if (o !== e.v) begin n_mis++; $display("FAIL %s: got %0h expected %0h", e.name, o, e.v); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 10; i < 15; i++) begin
            bus.rsv_valid = 1'b1; bus.rsv_index = reg_idx_t'(i);
            #1;
            expect_v($sformatf("b2b_rsv_ready_%0d", i), 1); observe(bus.rsv_ready);
            tick();
        end
        bus.rsv_valid = 1'b0;
        for (int i = 10; i < 15; i++) begin
            bus.wr_valid = 1'b1; bus.wr_index = reg_idx_t'(i);
            bus.wr_data  = word_t'($urandom);
            mdl[i] = bus.wr_data;
            tick();
        end
        bus.wr_valid = 1'b0;
        for (int i = 10; i < 15; i++) begin
            bus.rd_index_b = reg_idx_t'(i);
            #1;
            expect_v($sformatf("b2b_read_%0d", i), mdl[i]); observe(bus.rd_data_b);
            expect_v($sformatf("b2b_busy_%0d", i), 0);      observe(bus.rd_busy_b);
        end
        expect_v("b2b_r3_intact", mdl[3]); bus.rd_index_b = 4'd3; #1; observe(bus.rd_data_b);
        expect_v("b2b_err", 0); observe(bus.err);
        while (sb_exp.size() > 0) begin
            exp_t e = sb_exp.pop_front();
            logic [31:0] o = sb_obs.pop_front();
            n_cmp++;
            if (o !== e.v) begin n_mis++; $display("FAIL %s: got %0h expected %0h", e.name, o, e.v); end
        end
    endtask

    task automatic test_err_and_reset();
        bus.wr_valid = 1'b1; bus.wr_index = 4'd7; bus.wr_data = 16'hDEAD; bus.rd_index_a = 4'd7;
        #1;
        expect_v("r7_err_before", 0); observe(bus.err);
        tick();
        bus.wr_valid = 1'b0;
        #1;
        expect_v("r7_err_set", 1);    observe(bus.err);
        expect_v("r7_data", 16'hDEAD); observe(bus.rd_data_a);
        tick(); tick(); tick();
        expect_v("r7_err_sticky", 1); observe(bus.err);
        bus.wr_valid = 1'b1; bus.wr_data = 16'h7777;
        #2;
        reset_n = 1'b0;
        #1;
        expect_v("mid_rst_data", 0);     observe(bus.rd_data_a);
        expect_v("mid_rst_err", 0);      observe(bus.err);
        expect_v("mid_rst_wr_ready", 0); observe(bus.wr_ready);
        tick();
        bus.wr_valid = 1'b0;
        reset_n = 1'b1;
        tick(); tick();
        expect_v("post_rst_r7", 0);       observe(bus.rd_data_a);
        expect_v("post_rst_wr_ready", 1); observe(bus.wr_ready);
        expect_v("post_rst_err", 0);      observe(bus.err);
        bus.rd_index_b = 4'd3;
        #1;
        expect_v("post_rst_r3", 0);       observe(bus.rd_data_b);
        while (sb_exp.size() > 0) begin
            exp_t e = sb_exp.pop_front();
            logic [31:0] o = sb_obs.pop_front();
            n_cmp++;
            if (o !== e.v) begin n_mis++; $display("FAIL %s: got %0h expected %0h", e.name, o, e.v); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        for (int i = 0; i < NUM_REGS; i++) mdl[i] = '0;
        test_reset();
        test_reserve_write();
        test_waw();
        test_reg0();
        test_bypass();
        test_back_to_back();
        test_err_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
